bus_pack: RTL and testbench

Word-to-bus assembler: accepts a stream of `WORD_SIZE`-bit words over a valid/ready handshake and packs `WORD_NUM` of them into one `BUS_SIZE`-bit bus word with a per-lane control mask. It is the receive-side counterpart of the bus splitter: the first word received lands in the most-significant lane, and `control[k]` flags lane k. A `word_last` marker flushes a partially filled bus. The output uses a valid/ready handshake toward the downstream consumer.

---
 rtl/bus_pack.sv | 95 +++++++++
 tb/tb_bus_pack.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/bus_pack.sv
// bus_pack: packs WORD_NUM input words (first word in the top lane) into one bus word with a per-lane nonzero mask.
// Optional even-parity output is enabled by defining BUS_PACK_PARITY_EN.
module bus_pack #(
    parameter int BUS_SIZE  = 16,
    parameter int WORD_SIZE = 4,
    localparam int WORD_NUM = BUS_SIZE / WORD_SIZE
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [WORD_SIZE-1:0] word_in,
    input  logic                 word_valid,
    input  logic                 word_last,
    output logic                 word_ready,
    output logic [BUS_SIZE-1:0]  data_out,
    output logic [WORD_NUM-1:0]  control,
    output logic                 data_valid,
    input  logic                 data_ready
`ifdef BUS_PACK_PARITY_EN
    ,
    output logic                 parity_out
`endif
);

    localparam int IDX_W = (WORD_NUM > 1) ? $clog2(WORD_NUM) : 1;
    localparam logic [IDX_W-1:0] IDX_MAX = IDX_W'(WORD_NUM - 1);

    typedef enum logic {
        FILL = 1'b0,
        HOLD = 1'b1
    } state_t;

    state_t              state;
    logic [IDX_W-1:0]    idx;
    logic [IDX_W-1:0]    lane;
    logic [BUS_SIZE-1:0] bus_next;
    logic [WORD_NUM-1:0] ctrl_next;
    logic                close;

    assign word_ready = (state == FILL) && !reset;
    assign lane       = IDX_MAX - idx;
    assign close      = word_last || (idx == IDX_MAX);

    // Bus as it will look once the current word lands; parity is taken from this so it is ready with data_valid.
    always_comb begin
        bus_next = data_out;
        ctrl_next = control;
        bus_next[lane*WORD_SIZE +: WORD_SIZE] = word_in;
        ctrl_next[lane] = |word_in;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= FILL;
            idx        <= '0;
            data_out   <= '0;
            control    <= '0;
            data_valid <= 1'b0;
`ifdef BUS_PACK_PARITY_EN
            parity_out <= 1'b0;
`endif
        end else begin
            case (state)
                FILL: begin
                    if (word_valid) begin
                        data_out <= bus_next;
                        control  <= ctrl_next;
                        if (close) begin
                            state      <= HOLD;
                            data_valid <= 1'b1;
                            idx        <= '0;
`ifdef BUS_PACK_PARITY_EN
                            parity_out <= ^bus_next;
`endif
                        end else begin
                            idx <= idx + IDX_W'(1);
                        end
                    end
                end
                HOLD: begin
                    if (data_ready) begin
                        state      <= FILL;
                        data_valid <= 1'b0;
                        data_out   <= '0;
                        control    <= '0;
`ifdef BUS_PACK_PARITY_EN
                        parity_out <= 1'b0;
`endif
                    end
                end
                default: state <= FILL;
            endcase
        end
    end

endmodule

// File: tb/tb_bus_pack.sv
// Directed self-checking bench for bus_pack (16-bit bus, 4-bit words).
// Parity checks are compiled in when BUS_PACK_PARITY_EN is defined.
module tb_bus_pack;

    logic        clk = 1'b0;
    logic        reset;
    logic [3:0]  word_in;
    logic        word_valid;
    logic        word_last;
    logic        word_ready;
    logic [15:0] data_out;
    logic [3:0]  control;
    logic        data_valid;
    logic        data_ready;
`ifdef BUS_PACK_PARITY_EN
    logic        parity_out;
`endif

    int n_cmp = 0;
    int n_err = 0;

    bus_pack #(.BUS_SIZE(16), .WORD_SIZE(4)) dut (
        .clk(clk),
        .reset(reset),
        .word_in(word_in),
        .word_valid(word_valid),
        .word_last(word_last),
        .word_ready(word_ready),
        .data_out(data_out),
        .control(control),
        .data_valid(data_valid),
        .data_ready(data_ready)
`ifdef BUS_PACK_PARITY_EN
        ,
        .parity_out(parity_out)
`endif
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic send(input logic [3:0] w, input logic l);
        word_in    = w;
        word_valid = 1'b1;
        word_last  = l;
        tick();
        word_valid = 1'b0;
        word_last  = 1'b0;
    endtask

    task automatic chk_bus(input string tag, input logic [15:0] d, input logic [3:0] c);
        chk({tag, "_data"}, 32'(data_out), 32'(d));
        chk({tag, "_ctrl"}, 32'(control), 32'(c));
        chk({tag, "_valid"}, 32'(data_valid), 32'd1);
        chk({tag, "_ready"}, 32'(word_ready), 32'd0);
    endtask

    task automatic release_bus(input string tag);
        data_ready = 1'b1;
        tick();
        chk({tag, "_rel_valid"}, 32'(data_valid), 32'd0);
        chk({tag, "_rel_data"}, 32'(data_out), 32'd0);
        chk({tag, "_rel_ready"}, 32'(word_ready), 32'd1);
    endtask

    initial begin
        reset      = 1'b1;
        word_in    = '0;
        word_valid = 1'b0;
        word_last  = 1'b0;
        data_ready = 1'b0;
        tick();
        tick();
        chk("rst_data", 32'(data_out), 32'd0);
        chk("rst_ctrl", 32'(control), 32'd0);
        chk("rst_valid", 32'(data_valid), 32'd0);
        chk("rst_ready", 32'(word_ready), 32'd0);
`ifdef BUS_PACK_PARITY_EN
        chk("rst_parity", 32'(parity_out), 32'd0);
`endif
        reset = 1'b0;
        #1;
        chk("fill_ready", 32'(word_ready), 32'd1);

        // Full bus, data_ready tied high
        data_ready = 1'b1;
        send(4'hA, 1'b0);
        send(4'hB, 1'b0);
        send(4'hC, 1'b0);
        chk("abcd_not_yet", 32'(data_valid), 32'd0);
        send(4'hD, 1'b0);
        chk_bus("abcd", 16'hABCD, 4'b1111);
`ifdef BUS_PACK_PARITY_EN
        chk("abcd_parity", 32'(parity_out), 32'd0);
`endif
        release_bus("abcd");

        // Zero word clears its control bit
        send(4'h1, 1'b0);
        send(4'h0, 1'b0);
        send(4'h2, 1'b0);
        send(4'h3, 1'b0);
        chk_bus("z1023", 16'h1023, 4'b1011);
        release_bus("z1023");

        // Early word_last flushes a partial bus
        send(4'h5, 1'b0);
        send(4'h6, 1'b1);
        chk_bus("last56", 16'h5600, 4'b1100);
        release_bus("last56");
        send(4'h3, 1'b1);
        chk_bus("restart_lane3", 16'h3000, 4'b1000);
        release_bus("restart_lane3");

        // Back-pressure: bus held, pending word not consumed
        data_ready = 1'b0;
        send(4'hA, 1'b0);
        send(4'hB, 1'b0);
        send(4'hC, 1'b0);
        send(4'hD, 1'b0);
        word_in    = 4'h7;
        word_valid = 1'b1;
        word_last  = 1'b0;
        for (int i = 0; i < 3; i++) begin
            chk("hold_bus", 32'(data_out), 32'hABCD);
            chk("hold_valid", 32'(data_valid), 32'd1);
            chk("hold_ready", 32'(word_ready), 32'd0);
            tick();
        end
        chk("hold_end_ctrl", 32'(control), 32'hF);
        data_ready = 1'b1;
        tick();
        chk("bp_rel_valid", 32'(data_valid), 32'd0);
        chk("bp_rel_ready", 32'(word_ready), 32'd1);
        word_last = 1'b1;
        tick();
        word_valid = 1'b0;
        word_last  = 1'b0;
        chk_bus("bp_seven", 16'h7000, 4'b1000);
`ifdef BUS_PACK_PARITY_EN
        chk("seven_parity", 32'(parity_out), 32'd1);
`endif
        release_bus("bp_seven");

        // Reset mid-fill
        send(4'h9, 1'b0);
        send(4'h8, 1'b0);
        chk("partial_data", 32'(data_out), 32'h9800);
        chk("partial_valid", 32'(data_valid), 32'd0);
        reset = 1'b1;
        tick();
        chk("midrst_data", 32'(data_out), 32'd0);
        chk("midrst_ctrl", 32'(control), 32'd0);
        chk("midrst_valid", 32'(data_valid), 32'd0);
        chk("midrst_ready", 32'(word_ready), 32'd0);
        reset = 1'b0;
        send(4'h9, 1'b0);
        send(4'h8, 1'b0);
        send(4'h7, 1'b0);
        send(4'h6, 1'b0);
        chk_bus("b9876", 16'h9876, 4'b1111);
        release_bus("b9876");

        // word_last without word_valid is ignored
        word_last = 1'b1;
        tick();
        word_last = 1'b0;
        chk("lastnv_valid", 32'(data_valid), 32'd0);
        send(4'h1, 1'b0);
        chk("lastnv_one_word", 32'(data_valid), 32'd0);
        send(4'h2, 1'b0);
        send(4'h3, 1'b0);
        send(4'h4, 1'b0);
        chk_bus("b1234", 16'h1234, 4'b1111);
        release_bus("b1234");

        // Single set bit in the bottom lane
        send(4'h0, 1'b0);
        send(4'h0, 1'b0);
        send(4'h0, 1'b0);
        send(4'h1, 1'b0);
        chk_bus("b0001", 16'h0001, 4'b0001);
`ifdef BUS_PACK_PARITY_EN
        chk("b0001_parity", 32'(parity_out), 32'd1);
`endif
        release_bus("b0001");
`ifdef BUS_PACK_PARITY_EN
        chk("rel_parity", 32'(parity_out), 32'd0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
